// File: rtl/ccip_mmio_initiator.sv
// ccip_mmio_initiator
//
// Host-side CCI-P MMIO initiator. Accepts one 64-bit MMIO command at a time,
// drives it onto the AFU c0 MMIO request channel with a rolling 9-bit TID,
// then reports a single-cycle completion: write done, read data, read timeout
// or read response with the wrong TID.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_*             command in (valid/ready handshake, write flag, addr, wdata)
//   rsp_*             completion out (one-cycle valid, read data, status)
//   mmio_*  (out)     AFU c0 MMIO request: rd/wr valid, address, length, tid, data
//   mmio_rsp_* (in)   AFU c2 MMIO read response: valid, tid, data
//   err_stray         sticky flag: a read response arrived while not waiting
//
// All outputs are registered.
module ccip_mmio_initiator #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        mmio_rd_valid,
    output logic        mmio_wr_valid,
    output logic [15:0] mmio_addr,
    output logic [1:0]  mmio_length,
    output logic [8:0]  mmio_tid,
    output logic [63:0] mmio_wdata,
    input  logic        mmio_rsp_valid,
    input  logic [8:0]  mmio_rsp_tid,
    input  logic [63:0] mmio_rsp_data,
    output logic        err_stray
);

    localparam logic [1:0]  StatusOk       = 2'b00;
    localparam logic [1:0]  StatusTimeout  = 2'b01;
    localparam logic [1:0]  StatusTidError = 2'b10;
    localparam logic [1:0]  Len8Bytes      = 2'b01;
    localparam logic [15:0] TmoLast        = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e      state_q;
    logic [8:0]  tid_q;      // TID for the next transaction
    logic [15:0] tmo_q;      // cycles already spent in StWait
    logic        is_write_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            tid_q         <= 9'd0;
            tmo_q         <= 16'd0;
            is_write_q    <= 1'b0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 64'd0;
            rsp_status    <= StatusOk;
            mmio_rd_valid <= 1'b0;
            mmio_wr_valid <= 1'b0;
            mmio_addr     <= 16'd0;
            mmio_length   <= Len8Bytes;
            mmio_tid      <= 9'd0;
            mmio_wdata    <= 64'd0;
            err_stray     <= 1'b0;
        end else begin
            // Single-cycle strobes default low.
            mmio_rd_valid <= 1'b0;
            mmio_wr_valid <= 1'b0;
            rsp_valid     <= 1'b0;
            mmio_length   <= Len8Bytes;

            if (mmio_rsp_valid && (state_q != StWait)) begin
                err_stray <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready     <= 1'b0;
                        is_write_q    <= cmd_write;
                        // 8-byte access: address is in 4-byte units, so bit 0 is cleared.
                        mmio_addr     <= cmd_addr & 16'hFFFE;
                        mmio_wdata    <= cmd_wdata;
                        mmio_tid      <= tid_q;
                        mmio_rd_valid <= ~cmd_write;
                        mmio_wr_valid <= cmd_write;
                        state_q       <= StIssue;
                    end else begin
                        // cmd_ready comes up one cycle after reset or RESP.
                        cmd_ready <= 1'b1;
                    end
                end

                StIssue: begin
                    tid_q <= tid_q + 9'd1;
                    if (is_write_q) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= StatusOk;
                        rsp_rdata  <= 64'd0;
                        state_q    <= StResp;
                    end else begin
                        tmo_q   <= 16'd0;
                        state_q <= StWait;
                    end
                end

                StWait: begin
                    tmo_q <= tmo_q + 16'd1;
                    // A response in the expiry cycle takes priority over the timeout.
                    if (mmio_rsp_valid) begin
                        rsp_valid <= 1'b1;
                        state_q   <= StResp;
                        if (mmio_rsp_tid == mmio_tid) begin
                            rsp_status <= StatusOk;
                            rsp_rdata  <= mmio_rsp_data;
                        end else begin
                            rsp_status <= StatusTidError;
                            rsp_rdata  <= 64'd0;
                        end
                    end else if (tmo_q == TmoLast) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= StatusTimeout;
                        rsp_rdata  <= 64'd0;
                        state_q    <= StResp;
                    end
                end

                StResp: begin
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
